// File: rtl/id_ex_issue_latch.sv
// -----------------------------------------------------------------------------
// id_ex_issue_latch
//
// Decode-to-execute pipeline register with integrated multi-bank architectural
// register files (bank 0 integer with hardwired x0, banks 1+ floating-point).
// Each cycle the instruction in ID has its source operands read (with a
// same-cycle writeback bypass), is checked for a load-use hazard against the
// instruction held in EX, and is latched into the ID/EX register together
// with its decoded fields and an opaque control bundle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_pc, if_instr, if_valid instruction in ID
//   dec_*                     decoder/immediate-generator side information
//   wb_we/wb_bank/wb_addr/wb_data  register-file writeback
//   hold                      EX stalled, ID/EX register keeps its contents
//   flush                     kill the instruction entering EX (wins over hold)
//   ex_*                      registered ID/EX outputs
//   load_use_stall            combinational, IF/ID holds while high
// -----------------------------------------------------------------------------
module id_ex_issue_latch #(
  parameter int                XLEN       = 32,
  parameter int                NBANK      = 2,
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] FLUSH_MASK = {CTRL_W{1'b1}},
  localparam int               BW         = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic              if_valid,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [BW-1:0]     dec_rs1_bank,
  input  logic [BW-1:0]     dec_rs2_bank,
  input  logic [BW-1:0]     dec_rd_bank,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              dec_mem_read,
  input  logic              wb_we,
  input  logic [BW-1:0]     wb_bank,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1,
  output logic [XLEN-1:0]   ex_rs2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [BW-1:0]     ex_rs1_bank,
  output logic [BW-1:0]     ex_rs2_bank,
  output logic [BW-1:0]     ex_rd_bank,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              load_use_stall
);

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign rd_addr  = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];

  // ---------------------------------------------------------------------------
  // Register files. The whole array clears on reset, so it is built from
  // flops rather than block RAM. Bank 0 entry 0 is never written, which keeps
  // x0 reading zero without a separate read-side mask.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NBANK][32];

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      for (genvar gj = 0; gj < 32; gj++) begin : g_reg
        localparam bit WRITABLE = !(gi == 0 && gj == 0);
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rf_q[gi][gj] <= '0;
          end else if (WRITABLE && wb_we && wb_bank == BW'(gi) && wb_addr == 5'(gj)) begin
            rf_q[gi][gj] <= wb_data;
          end
        end
      end
    end
  endgenerate

  // Asynchronous read; a bank select beyond NBANK-1 returns zero.
  logic [XLEN-1:0] rs1_arr;
  logic [XLEN-1:0] rs2_arr;

  always_comb begin
    rs1_arr = '0;
    rs2_arr = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (dec_rs1_bank == BW'(b)) rs1_arr = rf_q[b][rs1_addr];
      if (dec_rs2_bank == BW'(b)) rs2_arr = rf_q[b][rs2_addr];
    end
  end

  // Same-cycle writeback bypass; x0 of bank 0 is never forwarded.
  logic rs1_is_x0;
  logic rs2_is_x0;
  logic byp1;
  logic byp2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_is_x0 = (dec_rs1_bank == '0) && (rs1_addr == 5'd0);
  assign rs2_is_x0 = (dec_rs2_bank == '0) && (rs2_addr == 5'd0);
  assign byp1 = wb_we && (wb_bank == dec_rs1_bank) && (wb_addr == rs1_addr) && !rs1_is_x0;
  assign byp2 = wb_we && (wb_bank == dec_rs2_bank) && (wb_addr == rs2_addr) && !rs2_is_x0;
  assign rs1_val = byp1 ? wb_data : rs1_arr;
  assign rs2_val = byp2 ? wb_data : rs2_arr;

  // ---------------------------------------------------------------------------
  // Load-use hazard against the instruction currently in EX. A flush kills
  // the ID instruction's path into EX anyway, so no bubble is requested then.
  // ---------------------------------------------------------------------------
  logic              ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_q,      ex_rs1_d;
  logic [XLEN-1:0]   ex_rs2_q,      ex_rs2_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs1_addr_q, ex_rs1_addr_d;
  logic [4:0]        ex_rs2_addr_q, ex_rs2_addr_d;
  logic [4:0]        ex_rd_addr_q,  ex_rd_addr_d;
  logic [BW-1:0]     ex_rs1_bank_q, ex_rs1_bank_d;
  logic [BW-1:0]     ex_rs2_bank_q, ex_rs2_bank_d;
  logic [BW-1:0]     ex_rd_bank_q,  ex_rd_bank_d;
  logic [2:0]        ex_funct3_q,   ex_funct3_d;
  logic [6:0]        ex_funct7_q,   ex_funct7_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic              ex_mem_read_q, ex_mem_read_d;

  logic match1;
  logic match2;

  assign match1 = dec_rs1_used && (dec_rs1_bank == ex_rd_bank_q) &&
                  (rs1_addr == ex_rd_addr_q) && !rs1_is_x0;
  assign match2 = dec_rs2_used && (dec_rs2_bank == ex_rd_bank_q) &&
                  (rs2_addr == ex_rd_addr_q) && !rs2_is_x0;
  assign load_use_stall = ex_valid_q && ex_mem_read_q && !flush && (match1 || match2);

  // ---------------------------------------------------------------------------
  // ID/EX next state: flush > hold > load-use bubble > latch.
  // Bubbles only touch valid, mem_read and the masked control bits; the data
  // fields keep their previous values.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_addr_d = ex_rs1_addr_q;
    ex_rs2_addr_d = ex_rs2_addr_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_rs1_bank_d = ex_rs1_bank_q;
    ex_rs2_bank_d = ex_rs2_bank_q;
    ex_rd_bank_d  = ex_rd_bank_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7_d   = ex_funct7_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_mem_read_d = ex_mem_read_q;

    if (flush || (!hold && load_use_stall)) begin
      ex_valid_d    = 1'b0;
      ex_mem_read_d = 1'b0;
      ex_ctrl_d     = ex_ctrl_q & ~FLUSH_MASK;
    end else if (!hold) begin
      ex_valid_d    = if_valid;
      ex_pc_d       = if_pc;
      ex_rs1_d      = rs1_val;
      ex_rs2_d      = rs2_val;
      ex_imm_d      = dec_imm;
      ex_rs1_addr_d = rs1_addr;
      ex_rs2_addr_d = rs2_addr;
      ex_rd_addr_d  = rd_addr;
      ex_rs1_bank_d = dec_rs1_bank;
      ex_rs2_bank_d = dec_rs2_bank;
      ex_rd_bank_d  = dec_rd_bank;
      ex_funct3_d   = funct3;
      ex_funct7_d   = funct7;
      ex_ctrl_d     = if_valid ? dec_ctrl : (dec_ctrl & ~FLUSH_MASK);
      ex_mem_read_d = if_valid && dec_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_rs1_bank_q <= '0;
      ex_rs2_bank_q <= '0;
      ex_rd_bank_q  <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_q   <= '0;
      ex_ctrl_q     <= '0;
      ex_mem_read_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_addr_q <= ex_rs1_addr_d;
      ex_rs2_addr_q <= ex_rs2_addr_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_rs1_bank_q <= ex_rs1_bank_d;
      ex_rs2_bank_q <= ex_rs2_bank_d;
      ex_rd_bank_q  <= ex_rd_bank_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_q   <= ex_funct7_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_mem_read_q <= ex_mem_read_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1_addr = ex_rs1_addr_q;
  assign ex_rs2_addr = ex_rs2_addr_q;
  assign ex_rd_addr  = ex_rd_addr_q;
  assign ex_rs1_bank = ex_rs1_bank_q;
  assign ex_rs2_bank = ex_rs2_bank_q;
  assign ex_rd_bank  = ex_rd_bank_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7   = ex_funct7_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_mem_read = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_issue_latch.sv
// -----------------------------------------------------------------------------
// tb_id_ex_issue_latch
//
// Directed bench for id_ex_issue_latch: register-file write/read, bypass,
// x0 handling, FP bank, load-use bubble, bank-mismatch, hold, flush during
// hold, flush suppressing a stall and asynchronous reset mid-operation.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_id_ex_issue_latch;

  localparam int                XLEN   = 32;
  localparam int                NBANK  = 2;
  localparam int                CTRL_W = 16;
  localparam int                BW     = 1;
  localparam logic [CTRL_W-1:0] FMASK  = 16'h00FF;

  logic              clk;
  logic              rst;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic              if_valid;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic [BW-1:0]     dec_rs1_bank, dec_rs2_bank, dec_rd_bank;
  logic              dec_rs1_used, dec_rs2_used, dec_mem_read;
  logic              wb_we;
  logic [BW-1:0]     wb_bank;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              hold, flush;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [4:0]        ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [BW-1:0]     ex_rs1_bank, ex_rs2_bank, ex_rd_bank;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_read;
  logic              load_use_stall;

  int n_cmp;
  int n_err;

  id_ex_issue_latch #(
    .XLEN(XLEN), .NBANK(NBANK), .CTRL_W(CTRL_W), .FLUSH_MASK(FMASK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .dec_ctrl(dec_ctrl), .dec_imm(dec_imm),
    .dec_rs1_bank(dec_rs1_bank), .dec_rs2_bank(dec_rs2_bank), .dec_rd_bank(dec_rd_bank),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_mem_read(dec_mem_read),
    .wb_we(wb_we), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data),
    .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_bank(ex_rs1_bank), .ex_rs2_bank(ex_rs2_bank), .ex_rd_bank(ex_rd_bank),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [4:0] rd, input logic [2:0] f3,
                                     input logic [6:0] f7);
    mk = {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic set_id(input logic [31:0] pc, input logic [31:0] instr, input logic valid,
                        input logic [15:0] ctrl, input logic mem_rd,
                        input logic b1, input logic u1, input logic b2, input logic u2,
                        input logic bd);
    if_pc        = pc;
    if_instr     = instr;
    if_valid     = valid;
    dec_ctrl     = ctrl;
    dec_imm      = pc + 32'h1000;
    dec_mem_read = mem_rd;
    dec_rs1_bank = b1;
    dec_rs1_used = u1;
    dec_rs2_bank = b2;
    dec_rs2_used = u2;
    dec_rd_bank  = bd;
  endtask

  task automatic set_wb(input logic we, input logic bank, input logic [4:0] addr,
                        input logic [31:0] data);
    wb_we   = we;
    wb_bank = bank;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_id(32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #22;
    rst = 1'b0;
    #1;
    check("reset ex_valid", ex_valid, 0);
    check("reset ex_pc", ex_pc, 0);
    check("reset ex_rs1", ex_rs1, 0);
    check("reset ex_ctrl", ex_ctrl, 0);
    check("reset stall", load_use_stall, 0);
    @(posedge clk);
    #1;

    // Write x5, then read it back through the array.
    set_wb(1'b1, 1'b0, 5'd5, 32'h1234);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_id(32'h100, mk(5'd6, 5'd5, 5'd1, 3'd0, 7'd0), 1'b1, 16'hA5A5, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("x5 ex_rs1", ex_rs1, 32'h1234);
    check("x5 ex_rs2 unwritten", ex_rs2, 0);
    check("x5 ex_valid", ex_valid, 1);
    check("x5 ex_pc", ex_pc, 32'h100);
    check("x5 ex_imm", ex_imm, 32'h1100);
    check("x5 ex_rd_addr", ex_rd_addr, 1);
    check("x5 ex_ctrl", ex_ctrl, 16'hA5A5);

    // Same-cycle bypass of x7, with funct fields.
    set_wb(1'b1, 1'b0, 5'd7, 32'hDEADBEEF);
    set_id(32'h104, mk(5'd5, 5'd7, 5'd2, 3'd5, 7'h20), 1'b1, 16'h0001, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("bypass ex_rs1", ex_rs1, 32'hDEADBEEF);
    check("bypass ex_rs2", ex_rs2, 32'h1234);
    check("bypass ex_rs1_addr", ex_rs1_addr, 7);
    check("bypass ex_funct3", ex_funct3, 5);
    check("bypass ex_funct7", ex_funct7, 7'h20);

    // x0 write is dropped and never forwarded.
    set_wb(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
    set_id(32'h108, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle ex_valid", ex_valid, 0);
    set_id(32'h10C, mk(5'd0, 5'd0, 5'd3, 3'd0, 7'd0), 1'b1, 16'h0002, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("x0 ex_rs1", ex_rs1, 0);
    check("x0 ex_rs2", ex_rs2, 0);

    // Bank 1 f0 is a real register.
    set_wb(1'b1, 1'b1, 5'd0, 32'h3F800000);
    set_id(32'h110, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_id(32'h114, mk(5'd0, 5'd0, 5'd1, 3'd0, 7'd0), 1'b1, 16'h0003, 1'b0,
           1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("f0 ex_rs1", ex_rs1, 32'h3F800000);
    check("f0 ex_rs1_bank", ex_rs1_bank, 1);
    check("f0 ex_rd_bank", ex_rd_bank, 1);

    // Load-use: load to x3, then consumer of x3.
    set_id(32'h200, mk(5'd0, 5'd5, 5'd3, 3'd2, 7'd0), 1'b1, 16'hFFFF, 1'b1,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("load ex_mem_read", ex_mem_read, 1);
    set_id(32'h204, mk(5'd0, 5'd3, 5'd4, 3'd0, 7'd0), 1'b1, 16'h1234, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("loaduse stall", load_use_stall, 1);
    tick();
    check("bubble ex_valid", ex_valid, 0);
    check("bubble ex_ctrl", ex_ctrl, 16'hFF00);
    check("bubble ex_mem_read", ex_mem_read, 0);
    check("bubble ex_pc kept", ex_pc, 32'h200);
    check("after bubble stall", load_use_stall, 0);
    tick();
    check("replay ex_valid", ex_valid, 1);
    check("replay ex_pc", ex_pc, 32'h204);
    check("replay ex_rd_addr", ex_rd_addr, 4);

    // Bank mismatch: load writes f3, consumer reads x3.
    set_id(32'h300, mk(5'd0, 5'd5, 5'd3, 3'd2, 7'd0), 1'b1, 16'h00F0, 1'b1,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_id(32'h304, mk(5'd0, 5'd3, 5'd4, 3'd0, 7'd0), 1'b1, 16'h0F0F, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("bankmis stall", load_use_stall, 0);
    tick();
    check("bankmis ex_pc", ex_pc, 32'h304);

    // Hold for three cycles with changing ID inputs.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(32'h400 + 32'(4 * i), mk(5'd5, 5'd5, 5'd9, 3'd1, 7'd1), 1'b1,
             16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("hold ex_pc", ex_pc, 32'h304);
      check("hold ex_ctrl", ex_ctrl, 16'h0F0F);
    end
    hold = 1'b0;
    set_id(32'h40C, mk(5'd0, 5'd5, 5'd10, 3'd0, 7'd0), 1'b1, 16'hABCD, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("release ex_pc", ex_pc, 32'h40C);
    check("release ex_ctrl", ex_ctrl, 16'hABCD);

    // Flush while holding.
    hold  = 1'b1;
    flush = 1'b1;
    set_id(32'h410, mk(5'd0, 5'd5, 5'd11, 3'd0, 7'd0), 1'b1, 16'h1111, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    hold  = 1'b0;
    flush = 1'b0;
    check("holdflush ex_valid", ex_valid, 0);
    check("holdflush ex_ctrl", ex_ctrl, 16'hAB00);
    check("holdflush ex_pc", ex_pc, 32'h40C);

    // Flush suppresses a pending load-use stall.
    set_id(32'h500, mk(5'd0, 5'd5, 5'd3, 3'd2, 7'd0), 1'b1, 16'h00FF, 1'b1,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(32'h504, mk(5'd0, 5'd3, 5'd4, 3'd0, 7'd0), 1'b1, 16'h0001, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush masks stall", load_use_stall, 0);
    tick();
    flush = 1'b0;
    check("flush ex_valid", ex_valid, 0);
    check("flush ex_mem_read", ex_mem_read, 0);

    // Asynchronous reset between edges.
    set_id(32'h600, mk(5'd7, 5'd5, 5'd12, 3'd0, 7'd0), 1'b1, 16'h7777, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("prerst ex_valid", ex_valid, 1);
    check("prerst ex_rs1", ex_rs1, 32'h1234);
    #2;
    rst = 1'b1;
    #1;
    check("asyncrst ex_valid", ex_valid, 0);
    check("asyncrst ex_pc", ex_pc, 0);
    check("asyncrst ex_ctrl", ex_ctrl, 0);
    #1;
    rst = 1'b0;
    set_id(32'h700, mk(5'd7, 5'd5, 5'd13, 3'd0, 7'd0), 1'b1, 16'h0008, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("postrst ex_valid", ex_valid, 1);
    check("postrst ex_pc", ex_pc, 32'h700);
    check("postrst x5 cleared", ex_rs1, 0);
    check("postrst x7 cleared", ex_rs2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
